// File: rtl/ram_burst_reader.sv
// Burst read initiator for a synchronous-read RAM: streams len words starting at
// base_addr onto a valid/ready interface through a 2-entry skid buffer.
module ram_burst_reader #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   len,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DWIDTH-1:0] mem_dout,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [AWIDTH-1:0]   r_rd_ptr;
  logic [AWIDTH:0]     r_issue_cnt;
  logic [AWIDTH:0]     r_beat_cnt;
  logic                r_inflight;
  logic [DWIDTH-1:0]   r_buf [0:1];
  logic                r_wr_idx;
  logic                r_rd_idx;
  logic [1:0]          r_occ;

  logic                w_accept;
  logic                w_pop;
  logic                w_push;
  logic                w_issue;
  logic [2:0]          w_occ_proj;

  assign w_accept = (r_state == S_IDLE) && start;
  assign m_valid  = (r_occ != 2'd0);
  assign w_pop    = m_valid && m_ready;
  assign w_push   = r_inflight;

  // Occupancy as it will stand once this edge's pop and any in-flight word land;
  // a new read is only safe if that leaves a free slot for it.
  assign w_occ_proj = {1'b0, r_occ} - {2'b00, w_pop} + {2'b00, r_inflight};
  assign w_issue    = (r_state == S_READ) && (r_issue_cnt != '0) && (w_occ_proj < 3'd2);

  assign mem_addr = r_rd_ptr;
  assign mem_we   = 1'b0;
  assign m_data   = m_valid ? r_buf[r_rd_idx] : '0;
  assign m_last   = m_valid && (r_beat_cnt == (AWIDTH+1)'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (len != '0) ? S_READ : S_FIN;
        end
      end
      S_READ: begin
        if (w_pop && m_last) begin
          w_state_next = S_FIN;
        end
      end
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_READ:  busy = 1'b1;
      S_FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr    <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_rd_ptr    <= base_addr;
        r_issue_cnt <= len;
        r_beat_cnt  <= len;
      end else begin
        if (w_issue) begin
          r_rd_ptr    <= r_rd_ptr + AWIDTH'(1);
          r_issue_cnt <= r_issue_cnt - (AWIDTH+1)'(1);
        end
        if (w_pop) begin
          r_beat_cnt <= r_beat_cnt - (AWIDTH+1)'(1);
        end
      end
    end
  end

  // RAM data is valid the edge after its address was issued, so in-flight words always land here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_buf[i] <= '0;
      end
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_idx] <= mem_dout;
        r_wr_idx        <= ~r_wr_idx;
      end
      if (w_pop) begin
        r_rd_idx <= ~r_rd_idx;
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomised bench for ram_burst_reader: a behavioural RAM plus a word-queue
// reference model of each burst, with latency, stall-stability and reset checks.
module tb_ram_burst_reader;
  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          start   = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len     = '0;
  logic          m_ready = 1'b0;
  logic          busy, done, mem_we, m_valid, m_last;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout, m_data;

  logic [DW-1:0] ram [0:DEPTH-1];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] exp_q[$];
  int            addr_log[$];
  logic [DW-1:0] exp_word;
  int            beats_seen, done_cnt, done_cyc, first_cyc, busy_cyc;
  logic          hold_valid = 1'b0;
  logic [DW-1:0] hold_data;
  logic          hold_last;

  always #5 clock = ~clock;

  ram_burst_reader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  // Synchronous-read RAM: data for the address sampled on an edge appears after it.
  always @(posedge clock) begin
    mem_dout <= ram[mem_addr];
    cyc      <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  always @(negedge clock) begin
    check("mem_we_low", {63'd0, mem_we}, 64'd0);
    if (reset_n) begin
      if (busy) begin
        busy_cyc++;
        if (addr_log.size() == 0 || addr_log[$] != int'(mem_addr))
          addr_log.push_back(int'(mem_addr));
      end
      if (hold_valid) begin
        check("stall_data", {32'd0, m_data}, {32'd0, hold_data});
        check("stall_last", {63'd0, m_last}, {63'd0, hold_last});
      end
      hold_valid = m_valid && !m_ready;
      hold_data  = m_data;
      hold_last  = m_last;
      if (m_valid && first_cyc < 0) first_cyc = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'd1, 64'd0);
        end else begin
          exp_word = exp_q.pop_front();
          check("beat_data", {32'd0, m_data}, {32'd0, exp_word});
          check("beat_last", {63'd0, m_last}, {63'd0, exp_q.size() == 0});
        end
        beats_seen++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  task automatic clear_burst_state();
    exp_q.delete();
    addr_log.delete();
    beats_seen = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    first_cyc  = -1;
    busy_cyc   = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    {63'd0, busy},     64'd0);
    check({tag, "_done"},    {63'd0, done},     64'd0);
    check({tag, "_valid"},   {63'd0, m_valid},  64'd0);
    check({tag, "_last"},    {63'd0, m_last},   64'd0);
    check({tag, "_data"},    {32'd0, m_data},   64'd0);
    check({tag, "_memaddr"}, {61'd0, mem_addr}, 64'd0);
    check({tag, "_memwe"},   {63'd0, mem_we},   64'd0);
  endtask

  // mode 0: ready held high; 1: random ready; 2: 5-cycle stall after 2nd beat, then random.
  task automatic run_burst(input int b, input int l, input int mode, input bit repulse);
    int k, stalls, waited;
    clear_burst_state();
    for (int j = 0; j < l; j++) exp_q.push_back(ram[(b + j) % DEPTH]);
    @(posedge clock); #1;
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW+1)'(l);
    k         = cyc + 1;
    m_ready   = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    stalls    = 0;
    waited    = 0;
    while (done_cnt == 0 && waited < 300) begin
      @(posedge clock); #1;
      waited++;
      start = repulse && (waited == 3);
      if (start) begin
        base_addr = AW'(5);
        len       = (AW+1)'(3);
      end
      if (mode == 0) m_ready = 1'b1;
      else if (mode == 1) m_ready = 1'($urandom_range(0, 1));
      else if (beats_seen < 2) m_ready = 1'b1;
      else if (stalls < 5) begin
        m_ready = 1'b0;
        stalls++;
      end else m_ready = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    check("timeout", {63'd0, waited < 300}, 64'd1);
    repeat (2) @(posedge clock);
    #1;
    $display("burst base=%0d len=%0d mode=%0d repulse=%0d beats=%0d done_at=+%0d",
             b, l, mode, repulse, beats_seen, done_cyc - k);
    check("done_count",    done_cnt,   1);
    check("missing_beats", exp_q.size(), 0);
    check("beat_count",    beats_seen, l);
    check("idle_after",    {63'd0, busy}, 64'd0);
    check("addr_log_len",  addr_log.size(), l + 1);
    for (int i = 0; i <= l && i < addr_log.size(); i++)
      check("mem_addr_seq", addr_log[i], (b + i) % DEPTH);
    if (l == 0) begin
      check("len0_no_valid", first_cyc, -1);
      check("len0_done_lat", done_cyc - k, 0);
      check("len0_busy_cyc", busy_cyc, 1);
    end else begin
      check("first_valid_lat", first_cyc - k, 2);
      if (mode == 0) begin
        check("done_lat", done_cyc - k, 2 + l);
        check("busy_cyc", busy_cyc, l + 3);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 100);
    clear_burst_state();
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    run_burst(2, 4, 0, 1'b0);
    run_burst(6, 4, 0, 1'b0);
    run_burst(0, 8, 2, 1'b0);
    run_burst(3, 0, 0, 1'b0);
    run_burst(0, 6, 0, 1'b1);
    run_burst(5, 15, 0, 1'b0);

    // Reset in the middle of an 8-word burst.
    clear_burst_state();
    for (int j = 0; j < 8; j++) exp_q.push_back(ram[j]);
    @(posedge clock); #1;
    start = 1'b1; base_addr = '0; len = (AW+1)'(8); m_ready = 1'b1;
    waited = 0;
    while (beats_seen < 3 && waited < 100) begin
      @(posedge clock); #1;
      start = 1'b0;
      waited++;
    end
    check("reset_test_timeout", {63'd0, waited < 100}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    $display("mid-burst reset after %0d beats", beats_seen);
    check_reset_outputs("midreset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    run_burst(4, 2, 0, 1'b0);

    for (int n = 0; n < 14; n++)
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)),
                int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
